// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned LINE_BITS = 128
);
  logic                 i_req;
  logic [ADDR_BITS-1:0] i_addr;
  logic                 i_done;
  logic                 d_req;
  logic                 d_we;
  logic [ADDR_BITS-1:0] d_addr;
  logic [LINE_BITS-1:0] d_wdata;
  logic                 d_done;
  logic [LINE_BITS-1:0] rdata;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic                 mem_ack;
  logic [LINE_BITS-1:0] mem_rdata;

  // Arbiter view.
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_done, d_done, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Requester/memory environment view.
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_done, d_done, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises imem refills and dmem refills/write-backs onto one main-memory
// port; dmem has fixed priority, one transfer in flight at a time.
module mem_arbiter #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  localparam int unsigned OFFS_BITS = $clog2(LINE_BITS / 8);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
    end
  end

  // Next-state and registered-output logic; the memory side only ever sees latched values.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.d_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = {bus.d_addr[ADDR_BITS-1:OFFS_BITS], OFFS_BITS'(0)};
          mem_wdata_d = bus.d_wdata;
          state_d     = BUSY_D;
        end else if (bus.i_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {bus.i_addr[ADDR_BITS-1:OFFS_BITS], OFFS_BITS'(0)};
          state_d    = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) rdata_d = bus.mem_rdata;
          i_done_d  = (state_q == BUSY_I);
          d_done_d  = (state_q == BUSY_D);
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks for mem_arbiter: refills, write-back, priority, reset, spurious ack.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;
  int   i_cnt  = 0;
  int   d_cnt  = 0;
  int   both_cnt = 0;
  int   d_before;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_5A = {16{8'h5A}};
  localparam logic [127:0] LINE_X1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] LINE_X2 = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] LINE_X3 = 128'h3333_0000_3333_0000_3333_0000_3333_0000;
  localparam logic [127:0] LINE_X4 = 128'h4444_1111_4444_1111_4444_1111_4444_1111;

  mem_arbiter_if #(.ADDR_BITS(32), .LINE_BITS(128)) bus ();

  mem_arbiter #(.ADDR_BITS(32), .LINE_BITS(128)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Count done pulses mid-cycle.
  always @(negedge clock) begin
    if (bus.i_done) i_cnt++;
    if (bus.d_done) d_cnt++;
    if (bus.i_done && bus.d_done) both_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chka("rst_mem_addr", bus.mem_addr, 32'h0);
    chkw("rst_mem_wdata", bus.mem_wdata, 128'h0);
    chkw("rst_rdata", bus.rdata, 128'h0);
    chk1("rst_i_done", bus.i_done, 1'b0);
    chk1("rst_d_done", bus.d_done, 1'b0);

    // Simple imem refill, ack in third BUSY cycle
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_1040;
    tick();
    chk1("t1_mem_req", bus.mem_req, 1'b1);
    chka("t1_mem_addr", bus.mem_addr, 32'h0000_1040);
    chk1("t1_mem_we", bus.mem_we, 1'b0);
    tick();
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_A5;
    chk1("t1_i_done_pre", bus.i_done, 1'b0);
    chk1("t1_mem_req_busy3", bus.mem_req, 1'b1);
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    chk1("t1_i_done", bus.i_done, 1'b1);
    chkw("t1_rdata", bus.rdata, LINE_A5);
    chk1("t1_mem_req_resp", bus.mem_req, 1'b0);
    bus.i_req = 1'b0;
    tick();
    chk1("t1_i_done_off", bus.i_done, 1'b0);
    chkn("t1_i_cnt", i_cnt, 1);
    chkn("t1_d_cnt", d_cnt, 0);

    // Address alignment, immediate ack (3-cycle round trip)
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_104C;
    tick();
    chka("t2_mem_addr", bus.mem_addr, 32'h0000_1040);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_5A;
    tick();
    bus.mem_ack = 1'b0;
    chk1("t2_i_done", bus.i_done, 1'b1);
    chkw("t2_rdata", bus.rdata, LINE_5A);
    bus.i_req = 1'b0;
    tick();

    // dmem write-back leaves rdata untouched
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 128'h1234;
    tick();
    chk1("t3_mem_we", bus.mem_we, 1'b1);
    chkw("t3_mem_wdata", bus.mem_wdata, 128'h1234);
    chka("t3_mem_addr", bus.mem_addr, 32'h200);
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 128'hDEAD_BEEF;
    tick();
    bus.mem_ack = 1'b0;
    chk1("t3_d_done", bus.d_done, 1'b1);
    chk1("t3_i_done", bus.i_done, 1'b0);
    chkw("t3_rdata_kept", bus.rdata, LINE_5A);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    chkn("t3_d_cnt", d_cnt, 1);

    // Simultaneous requests: dmem first
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h300;
    tick();
    chka("t4_first_addr", bus.mem_addr, 32'h300);
    chk1("t4_first_we", bus.mem_we, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_X1;
    tick();
    bus.mem_ack = 1'b0;
    chk1("t4_d_done", bus.d_done, 1'b1);
    chkw("t4_rdata_d", bus.rdata, LINE_X1);
    bus.d_req = 1'b0;
    tick();
    chk1("t4_gap_mem_req", bus.mem_req, 1'b0);
    tick();
    chk1("t4_second_req", bus.mem_req, 1'b1);
    chka("t4_second_addr", bus.mem_addr, 32'h100);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_X2;
    tick();
    bus.mem_ack = 1'b0;
    chk1("t4_i_done", bus.i_done, 1'b1);
    chkw("t4_rdata_i", bus.rdata, LINE_X2);
    bus.i_req = 1'b0;
    tick();
    chkn("t4_both", both_cnt, 0);
    chkn("t4_i_cnt", i_cnt, 3);
    chkn("t4_d_cnt", d_cnt, 2);

    // Reset mid-transaction abandons the transfer
    d_before    = d_cnt;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h400;
    bus.d_wdata = 128'h77;
    tick();
    chk1("t5_busy", bus.mem_req, 1'b1);
    reset     = 1'b1;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    reset = 1'b0;
    chk1("t5_mem_req", bus.mem_req, 1'b0);
    chka("t5_mem_addr", bus.mem_addr, 32'h0);
    tick();
    chk1("t5_no_d_done", bus.d_done, 1'b0);
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h500;
    tick();
    chka("t5_i_addr", bus.mem_addr, 32'h500);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_X3;
    tick();
    bus.mem_ack = 1'b0;
    chk1("t5_i_done", bus.i_done, 1'b1);
    chkw("t5_rdata", bus.rdata, LINE_X3);
    bus.i_req = 1'b0;
    tick();
    chkn("t5_d_cnt", d_cnt, d_before);

    // Spurious ack in IDLE and requester change after latching
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_A5;
    tick();
    bus.mem_ack = 1'b0;
    chk1("t6_idle_req", bus.mem_req, 1'b0);
    chk1("t6_idle_i_done", bus.i_done, 1'b0);
    chk1("t6_idle_d_done", bus.d_done, 1'b0);
    chkw("t6_idle_rdata", bus.rdata, LINE_X3);
    tick();
    chk1("t6_idle_done_late", bus.i_done | bus.d_done, 1'b0);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h600;
    tick();
    chka("t6_addr", bus.mem_addr, 32'h600);
    bus.d_addr  = 32'h700;
    bus.d_we    = 1'b1;
    bus.d_wdata = 128'h99;
    tick();
    chka("t6_addr_held", bus.mem_addr, 32'h600);
    chk1("t6_we_held", bus.mem_we, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = LINE_X4;
    tick();
    bus.mem_ack = 1'b0;
    chk1("t6_d_done", bus.d_done, 1'b1);
    chkw("t6_rdata", bus.rdata, LINE_X4);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    chkn("t6_both", both_cnt, 0);
    chkn("t6_i_cnt", i_cnt, 4);
    chkn("t6_d_cnt", d_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
